ahb_grant_ctrl: RTL and testbench

Grant generator for the 5-master AHB arbiter. It takes the bus requests and the 25-bit priority list from the priority controller, and returns the one-hot `hgrant` that the priority controller consumes to rotate its list. It also registers `hmaster` and `hmastlock` for the address/data muxes and slaves. It holds the grant for locked transfers and for fixed-length bursts, so ownership changes only at legal AHB boundaries.

---
 rtl/ahb_grant_ctrl.sv | 145 ++++++++++++++
 tb/tb_ahb_grant_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_grant_ctrl.sv
// Grant generator for the 5-master AHB arbiter: priority-list selection, lock and
// fixed-length burst hold, plus registered hmaster/hmastlock for the bus muxes.
module ahb_grant_ctrl #(
    parameter int DEF_MASTER = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [4:0]  hbusreq,
    input  logic [4:0]  hlock,
    input  logic [24:0] priout,
    input  logic        hready,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hburst,
    output logic [4:0]  hgrant,
    output logic [2:0]  hmaster,
    output logic        hmastlock
);

    localparam logic [1:0] ST_ARB    = 2'd0;
    localparam logic [1:0] ST_BURST  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] BURST_WRAP4 = 3'd2;

    localparam logic [4:0] DEF_GRANT = 5'(5'b00001 << DEF_MASTER);
    localparam logic [2:0] DEF_IDX   = 3'(DEF_MASTER);

    logic [1:0] state_r;
    logic [3:0] rem_r;
    logic [3:0] rem_next_s;
    logic [4:0] sel_s;
    logic [4:0] grant_next_s;
    logic [1:0] state_next_s;
    logic       lock_s;
    logic       burst_hold_s;

    function automatic logic is_onehot(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    function automatic logic [2:0] onehot_idx(input logic [4:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            idx = idx | (v[i] ? 3'(i) : 3'd0);
        end
        return idx;
    endfunction

    // Non-one-hot slots are skipped so the result can never be anything but one-hot.
    function automatic logic [4:0] select_grant(input logic [24:0] pri, input logic [4:0] req);
        logic [4:0] slot;
        logic [4:0] res;
        logic       found;
        res   = DEF_GRANT;
        found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            slot = pri[24 - 5*i -: 5];
            if (!found && is_onehot(slot) && ((slot & req) != 5'd0)) begin
                res   = slot;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] burst_rem(input logic [2:0] burst);
        logic [3:0] r;
        case (burst)
            3'd2, 3'd3: r = 4'd3;
            3'd4, 3'd5: r = 4'd7;
            3'd6, 3'd7: r = 4'd15;
            default:    r = 4'd0;
        endcase
        return r;
    endfunction

    // Remaining-beat tracking for the transfer accepted at this edge.
    always_comb begin
        rem_next_s = 4'd0;
        case (htrans)
            TR_IDLE:   rem_next_s = 4'd0;
            TR_BUSY:   rem_next_s = rem_r;
            TR_NONSEQ: rem_next_s = burst_rem(hburst);
            TR_SEQ: begin
                if ((hburst >= BURST_WRAP4) && (rem_r != 4'd0)) begin
                    rem_next_s = rem_r - 4'd1;
                end else begin
                    rem_next_s = 4'd0;
                end
            end
            default:   rem_next_s = 4'd0;
        endcase
    end

    // Lock beats burst hold; holding until rem reaches 1 hands over on the penultimate beat.
    always_comb begin
        sel_s        = select_grant(priout, hbusreq);
        lock_s       = |(hlock & hgrant);
        burst_hold_s = (rem_next_s >= 4'd2);
        grant_next_s = sel_s;
        state_next_s = ST_ARB;
        case (state_r)
            ST_ARB, ST_BURST, ST_LOCKED: begin
                if (lock_s) begin
                    grant_next_s = hgrant;
                    state_next_s = ST_LOCKED;
                end else if (burst_hold_s) begin
                    grant_next_s = hgrant;
                    state_next_s = ST_BURST;
                end else begin
                    grant_next_s = sel_s;
                    state_next_s = ST_ARB;
                end
            end
            default: begin
                grant_next_s = sel_s;
                state_next_s = ST_ARB;
            end
        endcase
    end

    // All state advances only on accepted phases; reset wins over a stalled bus.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            hgrant    <= DEF_GRANT;
            hmaster   <= DEF_IDX;
            hmastlock <= 1'b0;
            state_r   <= ST_ARB;
            rem_r     <= 4'd0;
        end else if (hready) begin
            hgrant    <= grant_next_s;
            hmaster   <= onehot_idx(hgrant);
            hmastlock <= lock_s;
            state_r   <= state_next_s;
            rem_r     <= rem_next_s;
        end
    end

endmodule

// File: tb/tb_ahb_grant_ctrl.sv
// Directed bench for ahb_grant_ctrl: an integer-level reference model checked every
// cycle, plus hand-computed expectations at the interesting edges.
module tb_ahb_grant_ctrl;

    localparam int DEF = 0;
    localparam logic [24:0] PRI_A = {5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
    localparam logic [24:0] PRI_B = {5'b00001, 5'b00100, 5'b01000, 5'b10000, 5'b00010};

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic [4:0]  hbusreq = 5'd0;
    logic [4:0]  hlock = 5'd0;
    logic [24:0] priout = PRI_A;
    logic        hready = 1'b1;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hburst = 3'd0;
    logic [4:0]  hgrant;
    logic [2:0]  hmaster;
    logic        hmastlock;

    int n_vec = 0;
    int n_bad = 0;

    int m_gnt = DEF;
    int m_master = DEF;
    int m_rem = 0;
    bit m_lock = 1'b0;
    bit m_valid = 1'b0;

    ahb_grant_ctrl #(.DEF_MASTER(DEF)) dut (
        .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
        .priout(priout), .hready(hready), .htrans(htrans), .hburst(hburst),
        .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // First requesting master in the first one-hot slot, else the default master.
    function automatic int model_sel(input logic [24:0] p, input logic [4:0] r);
        int slot;
        for (int s = 0; s < 5; s++) begin
            slot = int'((p >> (20 - 5*s)) & 25'h1F);
            if ($countones(slot) == 1 && (slot & int'(r)) != 0) return $clog2(slot);
        end
        return DEF;
    endfunction

    function automatic int model_rem(input int rem, input logic [1:0] tr, input logic [2:0] b);
        int beats;
        beats = (b < 3'd2) ? 1 : (4 << ((int'(b) - 2) / 2));
        case (tr)
            2'b00:   return 0;
            2'b01:   return rem;
            2'b10:   return beats - 1;
            default: return (b < 3'd2 || rem == 0) ? 0 : rem - 1;
        endcase
    endfunction

    always @(posedge hclk) begin
        if (hreset) begin
            m_gnt    <= DEF;
            m_master <= DEF;
            m_lock   <= 1'b0;
            m_rem    <= 0;
            m_valid  <= 1'b1;
        end else if (hready && m_valid) begin
            m_master <= m_gnt;
            m_lock   <= hlock[m_gnt];
            m_rem    <= model_rem(m_rem, htrans, hburst);
            m_gnt    <= (hlock[m_gnt] || model_rem(m_rem, htrans, hburst) >= 2)
                        ? m_gnt : model_sel(priout, hbusreq);
        end
    end

    always @(negedge hclk) begin
        if (m_valid) begin
            chk("model_hgrant", 32'(hgrant), 32'(5'b00001 << m_gnt));
            chk("model_hmaster", 32'(hmaster), 32'(m_master));
            chk("model_hmastlock", 32'(hmastlock), 32'(m_lock));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    task automatic xfer(input logic [1:0] tr, input logic [2:0] b);
        htrans = tr;
        hburst = b;
        step(1);
    endtask

    initial begin
        step(2);
        hreset = 1'b0;
        chk("rst_hgrant", 32'(hgrant), 32'h01);
        chk("rst_hmaster", 32'(hmaster), 32'd0);
        chk("rst_hmastlock", 32'(hmastlock), 32'd0);
        step(3);
        chk("idle_hgrant", 32'(hgrant), 32'h01);
        chk("idle_hmaster", 32'(hmaster), 32'd0);

        priout = PRI_B; hbusreq = 5'b10010;
        step(1);
        chk("prio_hgrant", 32'(hgrant), 32'h10);
        step(1);
        chk("prio_hmaster", 32'(hmaster), 32'd4);

        hready = 1'b0; hbusreq = 5'b00000;
        step(1);
        hbusreq = 5'b01000;
        step(2);
        chk("stall_hgrant", 32'(hgrant), 32'h10);
        hready = 1'b1;
        step(1);
        chk("stall_release", 32'(hgrant), 32'h08);

        hbusreq = 5'b00100;
        step(1);
        chk("lock_pre", 32'(hgrant), 32'h04);
        priout = PRI_A; hlock = 5'b00100; hbusreq = 5'b00101;
        step(1);
        chk("lock_hold", 32'(hgrant), 32'h04);
        chk("lock_mastlock", 32'(hmastlock), 32'd1);
        step(1);
        chk("lock_hold2", 32'(hgrant), 32'h04);
        hlock = 5'b00000;
        step(1);
        chk("lock_release", 32'(hgrant), 32'h01);
        chk("lock_mastlock0", 32'(hmastlock), 32'd0);

        // INCR4 without and with a BUSY beat
        for (int k = 0; k < 2; k++) begin
            hbusreq = 5'b01000;
            xfer(2'b00, 3'd0);
            chk("burst_grant_m3", 32'(hgrant), 32'h08);
            hbusreq = 5'b01010;
            xfer(2'b10, 3'd3);
            chk("burst_nonseq", 32'(hgrant), 32'h08);
            if (k == 1) begin
                xfer(2'b01, 3'd3);
                chk("burst_busy", 32'(hgrant), 32'h08);
            end
            xfer(2'b11, 3'd3);
            chk("burst_seq1", 32'(hgrant), 32'h08);
            xfer(2'b11, 3'd3);
            chk("burst_seq2", 32'(hgrant), 32'h02);
            xfer(2'b11, 3'd3);
            chk("burst_seq3", 32'(hgrant), 32'h02);
        end

        hbusreq = 5'b01000;
        xfer(2'b00, 3'd0);
        hbusreq = 5'b01010;
        xfer(2'b10, 3'd3);
        chk("early_hold", 32'(hgrant), 32'h08);
        xfer(2'b00, 3'd3);
        chk("early_idle", 32'(hgrant), 32'h02);

        hbusreq = 5'b01000;
        xfer(2'b00, 3'd0);
        hbusreq = 5'b01010;
        xfer(2'b10, 3'd5);
        xfer(2'b11, 3'd5);
        chk("rst_burst_hold", 32'(hgrant), 32'h08);
        hreset = 1'b1; hready = 1'b0;
        step(1);
        hreset = 1'b0; hready = 1'b1;
        chk("rst_burst_hgrant", 32'(hgrant), 32'h01);
        chk("rst_burst_hmaster", 32'(hmaster), 32'd0);
        hbusreq = 5'b01000;
        xfer(2'b11, 3'd5);
        chk("rst_rem_cleared", 32'(hgrant), 32'h08);

        hbusreq = 5'b00010; priout = {5'b00011, 20'd0};
        xfer(2'b00, 3'd0);
        chk("bad_slot_default", 32'(hgrant), 32'h01);
        hbusreq = 5'b00110; priout = {5'b00100, 5'b00100, 5'b00010, 5'b00001, 5'b10000};
        step(1);
        chk("dup_slot", 32'(hgrant), 32'h04);

        // WRAP16: handover exactly on the 14th SEQ
        priout = PRI_A; hbusreq = 5'b00001;
        xfer(2'b10, 3'd6);
        for (int j = 1; j <= 15; j++) begin
            xfer(2'b11, 3'd6);
            if (j == 13) chk("wrap16_hold", 32'(hgrant), 32'h04);
            if (j == 14) chk("wrap16_switch", 32'(hgrant), 32'h01);
        end
        xfer(2'b00, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
